// File: rtl/multicycle_shifter.sv
// rtl/multicycle_shifter.sv - iterative shifter/rotator, up to STEP bit positions per cycle
module multicycle_shifter #(
  parameter int XLEN = 32,
  parameter int STEP = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] x,
  input  logic [XLEN-1:0] y,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] shifter_out,
  output logic            err,
  output logic            busy
);

  localparam int SW = $clog2(XLEN);
  localparam logic [SW:0] STEP_K = (SW+1)'(STEP);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  typedef enum logic [2:0] {OP_SLL, OP_SRL, OP_SRA, OP_ROL, OP_ROR, OP_ILL} op_t;

  state_t state, state_next;
  op_t op, op_dec;
  logic [XLEN-1:0]   work, work_shifted;
  logic [2*XLEN-1:0] dbl_l, dbl_r;
  logic [SW-1:0]     rem, shamt;
  logic [SW:0]       rem_ext, k, rem_left;
  logic              accept, finish_now;
  logic              unused_y;

  assign shamt    = y[SW-1:0];
  assign unused_y = ^y[XLEN-1:SW];
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign accept    = in_valid && in_ready;

  always_comb begin
    op_dec = OP_ILL;
    if (funct7 == 7'b0110000 && funct3 == 3'b001)      op_dec = OP_ROL;
    else if (funct7 == 7'b0110000 && funct3 == 3'b101) op_dec = OP_ROR;
    else if (funct3 == 3'b001)                         op_dec = OP_SLL;
    else if (funct3 == 3'b101 && funct7[5])            op_dec = OP_SRA;
    else if (funct3 == 3'b101)                         op_dec = OP_SRL;
  end

  assign finish_now = (shamt == '0) || (op_dec == OP_ILL);

  // Per-cycle step is the smaller of STEP and the remaining distance.
  always_comb begin
    rem_ext  = {1'b0, rem};
    k        = (rem_ext > STEP_K) ? STEP_K : rem_ext;
    rem_left = rem_ext - k;
  end

  // Rotates use a doubled word so the wrapped bits fall out of the slice.
  always_comb begin
    dbl_l = {work, work} << k;
    dbl_r = {work, work} >> k;
    work_shifted = work;
    case (op)
      OP_SLL:  work_shifted = work << k;
      OP_SRL:  work_shifted = work >> k;
      OP_SRA:  work_shifted = $signed(work) >>> k;
      OP_ROL:  work_shifted = dbl_l[2*XLEN-1:XLEN];
      OP_ROR:  work_shifted = dbl_r[XLEN-1:0];
      default: work_shifted = work;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = finish_now ? DONE : BUSY;
      BUSY:    if (rem_left == '0) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      work        <= '0;
      rem         <= '0;
      op          <= OP_SLL;
      shifter_out <= '0;
      err         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            work <= x;
            rem  <= shamt;
            op   <= op_dec;
            if (finish_now) begin
              shifter_out <= (op_dec == OP_ILL) ? '0 : x;
              err         <= (op_dec == OP_ILL);
            end
          end
        end
        BUSY: begin
          work <= work_shifted;
          rem  <= rem_left[SW-1:0];
          if (rem_left == '0) begin
            shifter_out <= work_shifted;
            err         <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_shifter.sv
// tb/tb_multicycle_shifter.sv - directed self-checking bench for multicycle_shifter
module tb_multicycle_shifter;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] x;
  logic [31:0] y;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] shifter_out;
  logic        err;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  multicycle_shifter #(.XLEN(32), .STEP(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .funct3(funct3), .funct7(funct7),
    .out_valid(out_valid), .out_ready(out_ready),
    .shifter_out(shifter_out), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request, measure cycles to out_valid, check the result, leave DONE unconsumed.
  task automatic issue(input string tag, input logic [31:0] xv, input logic [31:0] yv,
                       input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] exp_out, input logic exp_err, input int exp_lat);
    int lat;
    x = xv; y = yv; funct3 = f3; funct7 = f7;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    check_eq({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check_eq({tag, "_out"}, 64'(shifter_out), 64'(exp_out));
    check_eq({tag, "_err"}, 64'(err), 64'(exp_err));
  endtask

  task automatic consume(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_eq({tag, "_idle"}, {62'd0, out_valid, in_ready}, 64'b01);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    x = '0; y = '0; funct3 = '0; funct7 = '0;
    tick(); tick();
    rst = 1'b0;
    check_eq("rst_in_ready",  64'(in_ready), 64'd1);
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_out",       64'(shifter_out), 64'd0);
    check_eq("rst_err",       64'(err), 64'd0);
    check_eq("rst_busy",      64'(busy), 64'd0);

    issue("sll31", 32'h0000_0001, 32'd31, 3'b001, 7'b0000000, 32'h8000_0000, 1'b0, 9);
    consume("sll31");
    issue("sra4",  32'h8000_0000, 32'd4, 3'b101, 7'b0100000, 32'hF800_0000, 1'b0, 2);
    consume("sra4");
    issue("srl4",  32'h8000_0000, 32'd4, 3'b101, 7'b0000000, 32'h0800_0000, 1'b0, 2);
    consume("srl4");
    issue("ror1",  32'h0000_0001, 32'd1, 3'b101, 7'b0110000, 32'h8000_0000, 1'b0, 2);
    consume("ror1");
    issue("rol33", 32'h8000_0000, 32'd33, 3'b001, 7'b0110000, 32'h0000_0001, 1'b0, 2);
    consume("rol33");
    issue("srl0",  32'hDEAD_BEEF, 32'd0, 3'b101, 7'b0000000, 32'hDEAD_BEEF, 1'b0, 1);
    consume("srl0");
    issue("ill",   32'h1234_5678, 32'd5, 3'b010, 7'b0000000, 32'h0000_0000, 1'b1, 1);
    consume("ill");
    issue("sra31", 32'h8000_0001, 32'd31, 3'b101, 7'b0100000, 32'hFFFF_FFFF, 1'b0, 9);
    consume("sra31");
    issue("ror8",  32'h1234_5678, 32'd8, 3'b101, 7'b0110000, 32'h7812_3456, 1'b0, 3);
    consume("ror8");
    issue("rol4",  32'h1234_5678, 32'd4, 3'b001, 7'b0110000, 32'h2345_6781, 1'b0, 2);
    consume("rol4");
    issue("srapos5", 32'h7000_0000, 32'd5, 3'b101, 7'b0100000, 32'h0380_0000, 1'b0, 3);
    consume("srapos5");
    issue("sll_hiy", 32'h0000_000F, 32'hFFFF_FFE3, 3'b001, 7'b0000000, 32'h0000_0078, 1'b0, 2);
    consume("sll_hiy");

    // Hold result for 5 cycles while a competing request is presented.
    issue("hold", 32'h0000_0003, 32'd2, 3'b001, 7'b0000000, 32'h0000_000C, 1'b0, 2);
    x = 32'hFFFF_FFFF; y = 32'd0; funct3 = 3'b101; funct7 = 7'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("hold_state", {61'd0, out_valid, in_ready, err}, 64'b100);
      check_eq("hold_out", 64'(shifter_out), 64'h0000_000C);
    end
    in_valid = 1'b0;
    consume("hold");
    tick();
    check_eq("hold_noqueue", {62'd0, out_valid, busy}, 64'b00);

    // Reset during a long shift discards it.
    x = 32'h1; y = 32'd31; funct3 = 3'b001; funct7 = 7'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    check_eq("mid_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("mid_rst_state", {61'd0, in_ready, out_valid, busy}, 64'b100);
    check_eq("mid_rst_out", 64'(shifter_out), 64'd0);
    for (int i = 0; i < 10; i++) tick();
    check_eq("mid_rst_noout", 64'(out_valid), 64'd0);
    issue("post_rst", 32'h0000_00F0, 32'd4, 3'b101, 7'b0000000, 32'h0000_000F, 1'b0, 2);
    consume("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
